tern_dot_seq: RTL and testbench

TERN_DOT_SEQ -- requirements
Module: tern_dot_seq

---
 rtl/tern_pkg.sv | 19 +
 rtl/tern_lane_sel.sv | 35 +++
 rtl/tern_dot_seq.sv | 135 +++++++++++++
 tb/tb_tern_dot_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tern_pkg.sv
// Shared encodings and types for the ternary-weight dot-product engine.
package tern_pkg;

    localparam int unsigned ACT_W  = 8;
    localparam int unsigned TERM_W = ACT_W + 1;
    localparam int unsigned WT_W   = 2;

    localparam logic [WT_W-1:0] W_POS  = 2'b01;
    localparam logic [WT_W-1:0] W_NEG  = 2'b11;
    localparam logic [WT_W-1:0] W_ZERO = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/tern_lane_sel.sv
// One lane of stage 1: registers +act, -act or 0 according to a ternary weight.
// The 9-bit result lets -(-128) become +128 without wrapping.
module tern_lane_sel
    import tern_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic [ACT_W-1:0]         i_act,
    input  logic [WT_W-1:0]          i_wt,
    output logic signed [TERM_W-1:0] o_term
);

    logic signed [TERM_W-1:0] w_ext;
    logic signed [TERM_W-1:0] r_term;

    assign w_ext  = {i_act[ACT_W-1], i_act};
    assign o_term = r_term;

    // Capture the selected term on an accepted beat; otherwise hold zero so idle cycles add nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_term <= '0;
        end else if (!i_en) begin
            r_term <= '0;
        end else begin
            case (i_wt)
                W_POS:   r_term <= w_ext;
                W_NEG:   r_term <= -w_ext;
                default: r_term <= '0;
            endcase
        end
    end

endmodule

// File: rtl/tern_dot_seq.sv
// Sequential ternary dot product: LANES activations per beat, VEC_LEN per result.
module tern_dot_seq
    import tern_pkg::*;
#(
    parameter int unsigned LANES   = 16,
    parameter int unsigned VEC_LEN = 4096,
    parameter int unsigned ACC_W   = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ACT_W*LANES-1:0]  in_act,
    input  logic [WT_W*LANES-1:0]   in_wt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum
);

    localparam int unsigned BEATS = VEC_LEN / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_beat_cnt;
    logic                     r_drain_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_out_sum;
    logic                     r_busy;
    logic                     r_in_ready;
    logic                     r_out_valid;

    logic                     w_accept;
    logic                     w_last;
    logic                     w_busy_nxt;
    logic                     w_in_ready_nxt;
    logic                     w_out_valid_nxt;
    logic                     w_load_sum;
    logic signed [ACC_W-1:0]  w_tree_sum;
    logic signed [TERM_W-1:0] w_terms [LANES];

    assign w_accept  = in_valid && r_in_ready;
    assign w_last    = (r_beat_cnt == CNT_W'(BEATS - 1));
    assign busy      = r_busy;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;

    // Stage 1: one registered select per lane.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        tern_lane_sel u_sel (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_accept),
            .i_act  (in_act[ACT_W*g +: ACT_W]),
            .i_wt   (in_wt[WT_W*g +: WT_W]),
            .o_term (w_terms[g])
        );
    end

    // Stage 2 adder: sign-extend every lane term to the accumulator width and sum.
    always_comb begin
        w_tree_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_tree_sum = w_tree_sum + ACC_W'(w_terms[i]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; DONE waits for the consumer to see out_valid before returning to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)                      w_state_nxt = RUN;
            RUN:     if (w_accept && w_last)         w_state_nxt = DRAIN;
            DRAIN:   if (r_drain_cnt)                w_state_nxt = DONE;
            DONE:    if (r_out_valid && out_ready)   w_state_nxt = IDLE;
            default:                                 w_state_nxt = IDLE;
        endcase
    end

    // Output decode; valid trails DONE entry by one edge so the result is already settled.
    always_comb begin
        w_busy_nxt      = (w_state_nxt != IDLE);
        w_in_ready_nxt  = (w_state_nxt == RUN);
        w_out_valid_nxt = (r_state == DONE) && (w_state_nxt == DONE);
        w_load_sum      = (r_state == DRAIN) && (w_state_nxt == DONE);
    end

    // Registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_busy      <= w_busy_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Beat counter and two-cycle drain timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt  <= '0;
            r_drain_cnt <= 1'b0;
        end else begin
            if (r_state == IDLE)  r_beat_cnt <= '0;
            else if (w_accept)    r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            r_drain_cnt <= (r_state == DRAIN) ? ~r_drain_cnt : 1'b0;
        end
    end

    // Accumulator: held clear in IDLE; lane registers are zero on non-accepted cycles.
    always_ff @(posedge clk) begin
        if (rst)                   r_acc <= '0;
        else if (r_state == IDLE)  r_acc <= '0;
        else                       r_acc <= r_acc + w_tree_sum;
    end

    // Result register, loaded as DONE is entered and held until the next load or reset.
    always_ff @(posedge clk) begin
        if (rst)             r_out_sum <= '0;
        else if (w_load_sum) r_out_sum <= r_acc;
    end

endmodule

// File: tb/tb_tern_dot_seq.sv
// Self-checking bench for tern_dot_seq with a behavioural dot-product model.
module tb_tern_dot_seq;

    localparam int unsigned LANES   = 16;
    localparam int unsigned VEC_LEN = 4096;
    localparam int unsigned ACC_W   = 24;
    localparam int unsigned BEATS   = VEC_LEN / LANES;

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic                     busy;
    logic                     in_valid;
    logic                     in_ready;
    logic [8*LANES-1:0]       in_act;
    logic [2*LANES-1:0]       in_wt;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_sum;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8*LANES-1:0] rand_act [BEATS];
    logic [2*LANES-1:0] rand_wt  [BEATS];

    tern_dot_seq #(.LANES(LANES), .VEC_LEN(VEC_LEN), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .in_wt     (in_wt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sum over lanes of act * {+1, -1, 0}; reserved code 10 counts as 0.
    function automatic longint beat_sum(input logic [8*LANES-1:0] act, input logic [2*LANES-1:0] wt);
        longint s = 0;
        for (int l = 0; l < LANES; l++) begin
            int a;
            logic [7:0] ab;
            logic [1:0] wb;
            ab = act[8*l +: 8];
            wb = wt[2*l +: 2];
            a  = int'($signed(ab));
            if (wb == 2'b01)      s = s + a;
            else if (wb == 2'b11) s = s - a;
        end
        return s;
    endfunction

    // Beat contents for each stimulus pattern.
    task automatic gen_beat(input int pat, input int b, output logic [8*LANES-1:0] act,
                            output logic [2*LANES-1:0] wt);
        act = '0;
        wt  = '0;
        if (pat == 5) begin
            act = rand_act[b];
            wt  = rand_wt[b];
        end else begin
            for (int l = 0; l < LANES; l++) begin
                case (pat)
                    0: begin act[8*l +: 8] = 8'd1;    wt[2*l +: 2] = 2'b01; end
                    1: begin act[8*l +: 8] = 8'h80;   wt[2*l +: 2] = 2'b11; end
                    2: begin
                        act[8*l +: 8] = 8'(l);
                        if (l == 15)         wt[2*l +: 2] = 2'b10;
                        else if (l % 2 == 0) wt[2*l +: 2] = 2'b01;
                        else                 wt[2*l +: 2] = 2'b11;
                    end
                    4: begin act[8*l +: 8] = 8'd127;  wt[2*l +: 2] = 2'b01; end
                    default: begin
                        act[8*l +: 8] = 8'($urandom);
                        wt[2*l +: 2]  = 2'($urandom);
                    end
                endcase
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present nb beats, optionally with random invalid gaps carrying garbage data.
    task automatic feed(input int pat, input int nb, input bit gaps, output longint exp, output bit timeout);
        logic [8*LANES-1:0] pa;
        logic [2*LANES-1:0] pw;
        int  acc_n = 0;
        int  cyc   = 0;
        bit  rdy;
        exp     = 0;
        timeout = 1'b0;
        gen_beat(pat, 0, pa, pw);
        while (acc_n < nb) begin
            if (cyc > 20 * nb + 100) begin
                timeout = 1'b1;
                break;
            end
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (in_valid) begin
                in_act = pa;
                in_wt  = pw;
            end else begin
                in_act = {$urandom, $urandom, $urandom, $urandom};
                in_wt  = 32'h5555_5555 | 32'($urandom);
            end
            rdy = in_ready;
            tick();
            cyc++;
            if (in_valid && rdy) begin
                exp = exp + beat_sum(pa, pw);
                acc_n++;
                if (acc_n < nb) gen_beat(pat, acc_n, pa, pw);
            end
        end
        in_valid = 1'b0;
        in_act   = '0;
        in_wt    = '0;
    endtask

    // Count edges from the final accepting edge until out_valid; 50 means it never came.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_tests++; if (out_sum !== '0) begin n_fail++; $display("FAIL reset_out_sum got %0d want 0", out_sum); end
        start = 1'b0;
        rst   = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset got %0b want 0", busy); end
    endtask

    // One full operation: latency, value against the model (and a constant if given), stall stability.
    task automatic test_pattern(input string name, input int pat, input bit gaps, input int stall,
                                input bit has_const, input longint cval, output longint got);
        longint exp;
        bit     to;
        int     n;
        logic signed [ACC_W-1:0] held;
        start_op();
        n_tests++; if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s_enter_run busy=%0b in_ready=%0b want 1/1", name, busy, in_ready);
        end
        feed(pat, BEATS, gaps, exp, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL %s_feed_timeout got timeout want %0d beats", name, BEATS); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s_drain_ready got %0b want 0", name, in_ready); end
        wait_valid(n);
        n_tests++; if (n !== 3) begin n_fail++; $display("FAIL %s_latency got %0d edges want 3", name, n); end
        n_tests++; if (64'(out_sum) !== exp) begin n_fail++; $display("FAIL %s_sum got %0d want %0d", name, out_sum, exp); end
        if (has_const) begin
            n_tests++; if (64'(out_sum) !== cval) begin n_fail++; $display("FAIL %s_const got %0d want %0d", name, out_sum, cval); end
        end
        got  = 64'(out_sum);
        held = out_sum;
        for (int c = 0; c < stall; c++) begin
            tick();
            n_tests++; if (out_valid !== 1'b1 || out_sum !== held) begin
                n_fail++; $display("FAIL %s_stall_cycle%0d valid=%0b sum=%0d want 1/%0d", name, c, out_valid, out_sum, held);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s_release busy=%0b valid=%0b want 0/0", name, busy, out_valid);
        end
    endtask

    task automatic test_main();
        longint g;
        test_pattern("ones",   0, 1'b0, 0, 1'b1, 64'd4096,   g);
        test_pattern("neg128", 1, 1'b0, 0, 1'b1, 64'd524288, g);
        test_pattern("ramp",   2, 1'b0, 2, 1'b1, 64'd1792,   g);
        test_pattern("random", 3, 1'b1, 3, 1'b0, 64'd0,      g);
    endtask

    task automatic test_back_to_back();
        longint a;
        longint b;
        for (int i = 0; i < int'(BEATS); i++) begin
            rand_act[i] = {$urandom, $urandom, $urandom, $urandom};
            rand_wt[i]  = 32'($urandom);
        end
        test_pattern("nostall", 5, 1'b0, 0,  1'b0, 64'd0, a);
        test_pattern("stall",   5, 1'b1, 20, 1'b0, 64'd0, b);
        n_tests++; if (b !== a) begin n_fail++; $display("FAIL stall_vs_nostall got %0d want %0d", b, a); end
    endtask

    task automatic test_abort();
        longint exp;
        longint g;
        bit     to;
        bit     spurious = 1'b0;
        start_op();
        feed(3, 100, 1'b1, exp, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL abort_feed_timeout got timeout want 100 beats"); end
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        n_tests++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== '0) begin
            n_fail++; $display("FAIL abort_reset busy=%0b rdy=%0b valid=%0b sum=%0d want all 0", busy, in_ready, out_valid, out_sum);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
        end
        n_tests++; if (spurious) begin n_fail++; $display("FAIL abort_spurious got activity want none"); end
        test_pattern("after_abort", 4, 1'b0, 0, 1'b1, 64'd520192, g);
    endtask

    task automatic test_start_ignored();
        longint exp;
        bit     to;
        int     n;
        start_op();
        start = 1'b1;
        feed(2, BEATS, 1'b1, exp, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL ign_feed_timeout got timeout want %0d beats", BEATS); end
        wait_valid(n);
        n_tests++; if (n !== 3) begin n_fail++; $display("FAIL ign_latency got %0d edges want 3", n); end
        n_tests++; if (64'(out_sum) !== 64'd1792) begin n_fail++; $display("FAIL ign_sum got %0d want 1792", out_sum); end
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL ign_exit busy=%0b valid=%0b want 0/0", busy, out_valid);
        end
        tick();
        tick();
        n_tests++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL ign_no_restart busy=%0b rdy=%0b want 0/0", busy, in_ready);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_act    = '0;
        in_wt     = '0;
        out_ready = 1'b0;
        test_reset();
        test_main();
        test_back_to_back();
        test_abort();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
